spi_csr_bridge: RTL and testbench

//  SPI slave (mode 0, MSB first) front end for the CSR register map; sits directly upstream of it.

---
 rtl/spi_csr_bridge_if.sv | 29 ++
 rtl/spi_csr_bridge.sv | 189 ++++++++++++++++++
 tb/tb_spi_csr_bridge.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_csr_bridge_if.sv
// SPI pins and CSR register-map port bundle for spi_csr_bridge.
// slave = the bridge side; master = the pin/register-map side.
`timescale 1ns/1ps
interface spi_csr_bridge_if #(
   parameter int unsigned ADDR_WIDTH = 7,
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  sck_i;
   logic                  csn_i;
   logic                  mosi_i;
   logic                  miso_o;
   logic                  miso_oe_o;
   logic [ADDR_WIDTH-1:0] addr_o;
   logic [DATA_WIDTH-1:0] write_data_o;
   logic                  write_en_o;
   logic                  read_en_o;
   logic [DATA_WIDTH-1:0] read_data_i;
   logic                  busy_o;

   modport slave (
      input  sck_i, csn_i, mosi_i, read_data_i,
      output miso_o, miso_oe_o, addr_o, write_data_o, write_en_o, read_en_o, busy_o
   );

   modport master (
      output sck_i, csn_i, mosi_i, read_data_i,
      input  miso_o, miso_oe_o, addr_o, write_data_o, write_en_o, read_en_o, busy_o
   );
endinterface

// File: rtl/spi_csr_bridge.sv
// SPI mode-0 slave that turns {rw,addr} + data byte frames into held CSR
// write/read strobes, with burst auto-increment and read prefetch.
`timescale 1ns/1ps
module spi_csr_bridge #(
   parameter int unsigned ADDR_WIDTH    = 7,
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned STROBE_CYCLES = 4,
   parameter int unsigned SYNC_STAGES   = 2
) (
   input  logic            clk_i,
   input  logic            rstn_n,
   spi_csr_bridge_if.slave bus
);
   localparam int unsigned     BW       = $clog2(DATA_WIDTH);
   localparam int unsigned     CW       = $clog2(STROBE_CYCLES);
   localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_WIDTH - 1);
   localparam logic [CW-1:0]   LAST_CNT = CW'(STROBE_CYCLES - 1);

   typedef enum logic [1:0] {F_IDLE, F_CMD, F_DATA} frame_t;
   typedef enum logic [1:0] {S_IDLE, S_WR, S_RD}    strobe_t;

   logic [SYNC_STAGES-1:0] r_sck_sync, r_csn_sync, r_mosi_sync;
   logic                   r_sck_prev;
   frame_t                 r_fstate, w_fstate_nxt;
   strobe_t                r_sstate, w_sstate_nxt;
   logic [BW-1:0]          r_bit_cnt;
   logic [DATA_WIDTH-2:0]  r_rx_shift;
   logic [DATA_WIDTH-1:0]  r_tx_shift;
   logic                   r_rw, r_oe, r_cap;
   logic [ADDR_WIDTH-1:0]  r_frame_addr, r_addr, r_pend_addr;
   logic [DATA_WIDTH-1:0]  r_wdata, r_pend_data;
   logic                   r_pend_wr, r_pend_rd;
   logic [CW-1:0]          r_cnt;

   logic                   w_sck, w_csn, w_mosi, w_sck_rise, w_sck_fall, w_active;
   logic                   w_byte_done, w_req_wr, w_req_rd, w_accept;
   logic [DATA_WIDTH-1:0]  w_byte;
   logic [ADDR_WIDTH-1:0]  w_req_addr;

   // csn synchroniser resets high so reset release never looks like a frame start
   always_ff @(posedge clk_i or negedge rstn_n) begin
      if (!rstn_n) begin
         r_sck_sync  <= '0;
         r_csn_sync  <= '1;
         r_mosi_sync <= '0;
         r_sck_prev  <= 1'b0;
      end else begin
         r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], bus.sck_i};
         r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], bus.csn_i};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi_i};
         r_sck_prev  <= w_sck;
      end
   end

   assign w_sck       = r_sck_sync[SYNC_STAGES-1];
   assign w_csn       = r_csn_sync[SYNC_STAGES-1];
   assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
   assign w_sck_rise  = w_sck & ~r_sck_prev;
   assign w_sck_fall  = ~w_sck & r_sck_prev;
   assign w_active    = (r_fstate != F_IDLE) && !w_csn;
   assign w_byte      = {r_rx_shift, w_mosi};
   assign w_byte_done = w_active && w_sck_rise && (r_bit_cnt == LAST_BIT);
   assign w_req_rd    = w_byte_done && (((r_fstate == F_CMD) && w_byte[DATA_WIDTH-1]) ||
                                        ((r_fstate == F_DATA) && r_rw));
   assign w_req_wr    = w_byte_done && (r_fstate == F_DATA) && !r_rw;
   assign w_req_addr  = (r_fstate == F_CMD) ? w_byte[ADDR_WIDTH-1:0] :
                        (r_rw ? r_frame_addr + 1'b1 : r_frame_addr);

   always_ff @(posedge clk_i or negedge rstn_n) begin
      if (!rstn_n) r_fstate <= F_IDLE;
      else         r_fstate <= w_fstate_nxt;
   end

   always_comb begin
      w_fstate_nxt = r_fstate;
      if (w_csn) begin
         w_fstate_nxt = F_IDLE;
      end else begin
         case (r_fstate)
            F_IDLE:  w_fstate_nxt = F_CMD;
            F_CMD:   if (w_byte_done) w_fstate_nxt = F_DATA;
            default: w_fstate_nxt = r_fstate;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rstn_n) begin
      if (!rstn_n) begin
         r_bit_cnt    <= '0;
         r_rx_shift   <= '0;
         r_rw         <= 1'b0;
         r_oe         <= 1'b0;
         r_frame_addr <= '0;
      end else if (w_csn) begin
         r_bit_cnt <= '0;
         r_oe      <= 1'b0;
      end else if (r_fstate == F_IDLE) begin
         r_bit_cnt <= '0;
         r_rw      <= 1'b0;
      end else if (w_sck_rise) begin
         r_rx_shift <= w_byte[DATA_WIDTH-2:0];
         r_bit_cnt  <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + 1'b1;
         if (r_bit_cnt == LAST_BIT) begin
            if (r_fstate == F_CMD) begin
               r_rw         <= w_byte[DATA_WIDTH-1];
               r_oe         <= w_byte[DATA_WIDTH-1];
               r_frame_addr <= w_byte[ADDR_WIDTH-1:0];
            end else begin
               r_frame_addr <= r_frame_addr + 1'b1;
            end
         end
      end
   end

   // One-deep request slot lets a new frame's strobe wait for a running one
   always_ff @(posedge clk_i or negedge rstn_n) begin
      if (!rstn_n) begin
         r_pend_wr   <= 1'b0;
         r_pend_rd   <= 1'b0;
         r_pend_addr <= '0;
         r_pend_data <= '0;
      end else if (w_req_wr || w_req_rd) begin
         r_pend_wr   <= w_req_wr;
         r_pend_rd   <= w_req_rd;
         r_pend_addr <= w_req_addr;
         r_pend_data <= w_byte;
      end else if (w_accept) begin
         r_pend_wr <= 1'b0;
         r_pend_rd <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_n) begin
      if (!rstn_n) begin
         r_sstate <= S_IDLE;
         r_cnt    <= '0;
      end else begin
         r_sstate <= w_sstate_nxt;
         r_cnt    <= (r_sstate != S_IDLE && w_sstate_nxt == r_sstate) ? r_cnt + 1'b1 : '0;
      end
   end

   always_comb begin
      w_sstate_nxt = r_sstate;
      w_accept     = 1'b0;
      case (r_sstate)
         S_IDLE: begin
            if (r_pend_wr) begin
               w_sstate_nxt = S_WR;
               w_accept     = 1'b1;
            end else if (r_pend_rd) begin
               w_sstate_nxt = S_RD;
               w_accept     = 1'b1;
            end
         end
         default: if (r_cnt == LAST_CNT) w_sstate_nxt = S_IDLE;
      endcase
   end

   // tx shifts only on falls inside a byte, so a capture between bytes keeps its MSB
   always_ff @(posedge clk_i or negedge rstn_n) begin
      if (!rstn_n) begin
         r_addr     <= '0;
         r_wdata    <= '0;
         r_cap      <= 1'b0;
         r_tx_shift <= '0;
      end else begin
         if (w_accept) begin
            r_addr <= r_pend_addr;
            if (r_pend_wr) r_wdata <= r_pend_data;
         end else if (r_sstate == S_WR && r_cnt == LAST_CNT) begin
            r_addr <= r_addr + 1'b1;
         end
         r_cap <= (r_sstate == S_RD) && (r_cnt == LAST_CNT);
         if (r_cap)
            r_tx_shift <= bus.read_data_i;
         else if (w_active && w_sck_fall && r_bit_cnt != '0)
            r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
      end
   end

   assign bus.addr_o       = r_addr;
   assign bus.write_data_o = r_wdata;
   assign bus.write_en_o   = (r_sstate == S_WR);
   assign bus.read_en_o    = (r_sstate == S_RD);
   assign bus.busy_o       = (r_sstate != S_IDLE);
   assign bus.miso_oe_o    = r_oe;
   assign bus.miso_o       = r_oe & r_tx_shift[DATA_WIDTH-1];
endmodule

// File: tb/tb_spi_csr_bridge.sv
// Bench for spi_csr_bridge: frame table plus abort/reset sequences, with a
// strobe scoreboard against a 3-stage-latency register map model.
`timescale 1ns/1ps
module tb_spi_csr_bridge;
   localparam int unsigned AW = 7, DW = 8, SC = 4;
   localparam time CLK_HALF = 5, SCK_HALF = 80;

   logic clk = 1'b0, rstn = 1'b0;
   always #CLK_HALF clk = ~clk;

   spi_csr_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif();

   spi_csr_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STROBE_CYCLES(SC), .SYNC_STAGES(2)) dut (
      .clk_i (clk),
      .rstn_n(rstn),
      .bus   (bif)
   );

   // Register map model: pattern a^0xA5 after reset, 3-cycle read latency
   logic [7:0] mem [128];
   logic [7:0] p1, p2, p3;
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int a = 0; a < 128; a++) mem[a] <= 8'(a) ^ 8'hA5;
         p1 <= '0; p2 <= '0; p3 <= '0;
      end else begin
         if (bif.write_en_o) mem[bif.addr_o] <= bif.write_data_o;
         p1 <= mem[bif.addr_o];
         p2 <= p1;
         p3 <= p2;
      end
   end
   assign bif.read_data_i = p3;

   typedef struct { bit wr; logic [6:0] addr; logic [7:0] data; } exp_t;
   typedef struct { bit rd; logic [6:0] addr; int unsigned n; logic [2:0][7:0] d; logic [2:0][7:0] e; } vec_t;

   exp_t sbq[$];
   int   n_checks = 0, n_pass = 0;
   bit   ignore_sb = 1'b0;
   vec_t vt [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic vec_t mk(input bit rd, input logic [6:0] addr, input int unsigned n,
                               input logic [7:0] d0, d1, d2, e0, e1, e2);
      vec_t v;
      v.rd = rd; v.addr = addr; v.n = n;
      v.d = {d2, d1, d0};
      v.e = {e2, e1, e0};
      return v;
   endfunction

   // Strobe monitor: measures each pulse and pops the scoreboard at its end
   initial begin
      bit pw, pr, p_wr, p_bad, ovl;
      int plen;
      logic [6:0] pa;
      logic [7:0] pd;
      exp_t e;
      pw = 0; pr = 0; ovl = 0; plen = 0; p_wr = 0; p_bad = 0; pa = '0; pd = '0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            pw = 0; pr = 0; ovl = 0;
         end else begin
            if (bif.write_en_o && bif.read_en_o) ovl = 1;
            if ((bif.write_en_o || bif.read_en_o) && !(pw || pr)) begin
               plen = 1; p_wr = bif.write_en_o; pa = bif.addr_o; pd = bif.write_data_o;
               p_bad = !bif.busy_o;
            end else if (bif.write_en_o || bif.read_en_o) begin
               plen++;
               if (bif.addr_o !== pa || bif.write_data_o !== pd || !bif.busy_o) p_bad = 1;
            end else if ((pw || pr) && !ignore_sb) begin
               chk("strobe_expected", 32'(sbq.size() != 0), 32'd1);
               if (sbq.size() != 0) begin
                  e = sbq.pop_front();
                  chk("strobe_kind", 32'(p_wr), 32'(e.wr));
                  chk("strobe_addr", 32'(pa), 32'(e.addr));
                  if (e.wr) chk("strobe_wdata", 32'(pd), 32'(e.data));
                  chk("strobe_len", 32'(plen), 32'(SC));
                  chk("strobe_stable_excl", 32'({p_bad, ovl}), 32'd0);
               end
               ovl = 0;
            end
            pw = bif.write_en_o; pr = bif.read_en_o;
         end
      end
   end

   task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = '0;
      for (int i = 0; i < nbits; i++) begin
         bif.mosi_i = tx[7-i];
         #(SCK_HALF);
         rx = {rx[6:0], bif.miso_o};
         bif.sck_i = 1'b1;
         #(SCK_HALF);
         bif.sck_i = 1'b0;
      end
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 400 && sbq.size() != 0; k++) @(negedge clk);
      chk({tag, "_drain"}, 32'(sbq.size()), 32'd0);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      logic [7:0] rx;
      exp_t x;
      if (v.rd) begin
         for (int i = 0; i <= int'(v.n); i++) begin
            x.wr = 0; x.addr = v.addr + 7'(i); x.data = '0; sbq.push_back(x);
         end
      end else begin
         for (int i = 0; i < int'(v.n); i++) begin
            x.wr = 1; x.addr = v.addr + 7'(i); x.data = v.d[i]; sbq.push_back(x);
         end
      end
      bif.csn_i = 1'b0;
      #(SCK_HALF);
      spi_xfer({v.rd, v.addr}, 8, rx);
      chk({tag, "_cmd_miso"}, 32'(rx), 32'd0);
      chk({tag, "_oe_after_cmd"}, 32'(bif.miso_oe_o), 32'(v.rd));
      for (int i = 0; i < int'(v.n); i++) begin
         spi_xfer(v.rd ? 8'h00 : v.d[i], 8, rx);
         chk($sformatf("%s_miso%0d", tag, i), 32'(rx), v.rd ? 32'(v.e[i]) : 32'd0);
      end
      #(SCK_HALF);
      bif.csn_i = 1'b1;
      #(4*SCK_HALF);
      chk({tag, "_oe_after_csn"}, 32'(bif.miso_oe_o), 32'd0);
      drain(tag);
   endtask

   initial begin
      logic [7:0] rx;
      bit seen;
      bif.sck_i = 1'b0; bif.csn_i = 1'b1; bif.mosi_i = 1'b0;
      rstn = 1'b0;
      repeat (5) @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_addr", 32'(bif.addr_o), 32'd0);
      chk("rst_wdata", 32'(bif.write_data_o), 32'd0);
      chk("rst_wen", 32'(bif.write_en_o), 32'd0);
      chk("rst_ren", 32'(bif.read_en_o), 32'd0);
      chk("rst_busy", 32'(bif.busy_o), 32'd0);
      chk("rst_oe", 32'(bif.miso_oe_o), 32'd0);
      chk("rst_miso", 32'(bif.miso_o), 32'd0);

      vt[0] = mk(0, 7'h03, 1, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      vt[1] = mk(1, 7'h03, 1, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h00);
      vt[2] = mk(0, 7'h7E, 3, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00);
      vt[3] = mk(1, 7'h0A, 3, 8'h00, 8'h00, 8'h00, 8'hAF, 8'hAE, 8'hA9);
      vt[4] = mk(1, 7'h7F, 2, 8'h00, 8'h00, 8'h00, 8'h22, 8'h33, 8'h00);
      vt[5] = mk(0, 7'h20, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("vec%0d", i));

      // Write aborted after 5 data bits: no strobe may follow
      bif.csn_i = 1'b0;
      #(SCK_HALF);
      spi_xfer(8'h01, 8, rx);
      spi_xfer(8'hFF, 5, rx);
      bif.csn_i = 1'b1;
      repeat (100) @(negedge clk);
      chk("abort_no_strobe_busy", 32'(bif.busy_o), 32'd0);
      run_vec(mk(0, 7'h01, 1, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), "abort_wr");
      run_vec(mk(1, 7'h01, 1, 8'h00, 8'h00, 8'h00, 8'hC3, 8'h00, 8'h00), "abort_rd");
      repeat (100) @(negedge clk);

      // Asynchronous reset in the middle of a write strobe
      ignore_sb = 1'b1;
      fork
         begin
            logic [7:0] rx2;
            bif.csn_i = 1'b0;
            #(SCK_HALF);
            spi_xfer(8'h40, 8, rx2);
            spi_xfer(8'h77, 8, rx2);
            #(SCK_HALF);
            bif.csn_i = 1'b1;
            #(4*SCK_HALF);
         end
         begin
            seen = 0;
            for (int k = 0; k < 4000 && !seen; k++) begin
               @(negedge clk);
               seen = bif.write_en_o;
            end
            chk("rst_mid_strobe_seen", 32'(seen), 32'd1);
            #15 rstn = 1'b0;
            #1;
            chk("rst_mid_wen", 32'(bif.write_en_o), 32'd0);
            chk("rst_mid_ren", 32'(bif.read_en_o), 32'd0);
            chk("rst_mid_busy", 32'(bif.busy_o), 32'd0);
            chk("rst_mid_addr", 32'(bif.addr_o), 32'd0);
            chk("rst_mid_wdata", 32'(bif.write_data_o), 32'd0);
            chk("rst_mid_oe", 32'(bif.miso_oe_o), 32'd0);
         end
      join
      #50 rstn = 1'b1;
      repeat (4) @(negedge clk);
      ignore_sb = 1'b0;
      run_vec(mk(0, 7'h41, 1, 8'h99, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), "post_rst_wr");
      run_vec(mk(1, 7'h41, 1, 8'h00, 8'h00, 8'h00, 8'h99, 8'h00, 8'h00), "post_rst_rd");

      drain("final");
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
      $fatal(1);
   end
endmodule
